// File: rtl/matmul_ctrl.sv
// Systolic-array matmul sequencer: clear, optional bias read, skewed operand feed, drain, write-back.
// Outputs are registered from the next-state decode; starts outside IDLE are rejected with a pulse.
module matmul_ctrl #(
  parameter int MAX_DIM     = 4,
  parameter int SP_NTARGETS = 4,
  parameter int DRAIN_CYC   = 1,
  localparam int DW = $clog2(MAX_DIM),
  localparam int SW = $clog2(3*MAX_DIM-2),
  localparam int AW = $clog2(SP_NTARGETS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [DW-1:0] dim_n_i,
  input  logic [DW-1:0] dim_k_i,
  input  logic [DW-1:0] dim_m_i,
  input  logic          bias_en_i,
  input  logic [AW-1:0] target_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          start_err_o,
  output logic          clear_acc_o,
  output logic          sp_rd_en_o,
  output logic          feed_en_o,
  output logic [SW-1:0] feed_step_o,
  output logic          sp_wr_en_o,
  output logic [AW-1:0] sp_addr_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_BIAS  = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] last_q;
  logic          bias_q;
  logic [AW-1:0] addr_q;
  logic          accept;

  logic          busy_q, done_q, err_q, clear_q, rd_q, feed_q, wr_q;
  logic [SW-1:0] step_q;

  assign accept = (state_q == S_IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_CLEAR;
      S_CLEAR: state_d = bias_q ? S_BIAS : S_FEED;
      S_BIAS:  state_d = S_FEED;
      S_FEED:  if (cnt_q == last_q) state_d = S_DRAIN;
      S_DRAIN: if (cnt_q == SW'(DRAIN_CYC-1)) state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change; it serves both FEED steps and DRAIN cycles.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && (state_q == S_FEED || state_q == S_DRAIN))
      cnt_d = cnt_q + SW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      bias_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        // Last feed step is F-1 = n+k+m in the minus-one encoding, which always fits SW bits.
        last_q <= SW'(dim_n_i) + SW'(dim_k_i) + SW'(dim_m_i);
        bias_q <= bias_en_i;
        addr_q <= target_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clear_q <= 1'b0;
      rd_q    <= 1'b0;
      feed_q  <= 1'b0;
      wr_q    <= 1'b0;
      step_q  <= '0;
    end else begin
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      err_q   <= start_i && (state_q != S_IDLE);
      clear_q <= (state_d == S_CLEAR);
      rd_q    <= (state_d == S_BIAS);
      feed_q  <= (state_d == S_FEED);
      wr_q    <= (state_d == S_WRITE);
      step_q  <= (state_d == S_FEED) ? cnt_d : '0;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign start_err_o = err_q;
  assign clear_acc_o = clear_q;
  assign sp_rd_en_o  = rd_q;
  assign feed_en_o   = feed_q;
  assign feed_step_o = step_q;
  assign sp_wr_en_o  = wr_q;
  assign sp_addr_o   = addr_q;

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_DIM, default 4, meaning the maximum matrix dimension of the systolic array, legal values 2..8.
REQ-002 The block SHALL have parameter SP_NTARGETS, default 4, meaning the number of scratchpad result slots, legal values 2..16.
REQ-003 The block SHALL have parameter DRAIN_CYC, default 1, meaning the PE pipeline drain cycles after the last operand, legal values 1..4.
REQ-004 Derived widths SHALL be DW=$clog2(MAX_DIM), SW=$clog2(3*MAX_DIM-2) and AW=$clog2(SP_NTARGETS).
REQ-005 The block SHALL have port clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port start_i  in  1  request to begin one multiplication, level sampled each cycle.
REQ-008 The block SHALL have ports dim_n_i / dim_k_i / dim_m_i  in  DW each  dimension minus 1 (0 encodes 1).
REQ-009 The block SHALL have port bias_en_i  in  1  accumulate onto the existing C from the scratchpad.
REQ-010 The block SHALL have port target_i  in  AW  scratchpad slot used for bias read and result write.
REQ-011 The block SHALL have port busy_o  out  1  operation in progress.
REQ-012 The block SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-013 The block SHALL have port start_err_o  out  1  one-cycle pulse, start rejected.
REQ-014 The block SHALL have port clear_acc_o  out  1  zero all PE accumulators.
REQ-015 The block SHALL have port sp_rd_en_o  out  1  read the bias matrix from slot sp_addr_o.
REQ-016 The block SHALL have port feed_en_o  out  1  operand injection active.
REQ-017 The block SHALL have port feed_step_o  out  SW  skew index of the current feed cycle.
REQ-018 The block SHALL have port sp_wr_en_o  out  1  write the result matrix to slot sp_addr_o.
REQ-019 The block SHALL have port sp_addr_o  out  AW  latched target slot.

Function
REQ-020 The FSM SHALL have states IDLE, CLEAR, BIAS, FEED, DRAIN, WRITE and DONE, with IDLE as the reset state.
REQ-021 In IDLE, start_i=1 SHALL latch the dimensions, bias_en_i and target_i, and the next state SHALL be CLEAR.
REQ-022 The latched values SHALL stay constant until the FSM returns to IDLE; input changes during an operation SHALL have no effect.
REQ-023 start_i=1 in any state other than IDLE SHALL be ignored, SHALL pulse start_err_o in the next cycle, and SHALL leave the sequence undisturbed.
REQ-024 CLEAR SHALL last 1 cycle with clear_acc_o=1, then go to BIAS if bias is latched, else to FEED.
REQ-025 BIAS SHALL last 1 cycle with sp_rd_en_o=1, then go to FEED.
REQ-026 FEED SHALL last F=(N+K+M-2) cycles, where N, K and M are the decoded dimensions (1..MAX_DIM).
REQ-027 In FEED, feed_en_o SHALL be 1 and feed_step_o SHALL count 0..F-1, incrementing by 1 each cycle.
REQ-028 F SHALL be computed at SW bits without overflow; the maximum is 3*MAX_DIM-2.
REQ-029 DRAIN SHALL last DRAIN_CYC cycles with all strobes low.
REQ-030 WRITE SHALL last 1 cycle with sp_wr_en_o=1.
REQ-031 DONE SHALL last 1 cycle with done_o=1 and busy_o=0, then go to IDLE.
REQ-032 busy_o SHALL be 1 in CLEAR, BIAS, FEED, DRAIN and WRITE, and 0 in IDLE and DONE.
REQ-033 A start_i=1 in DONE SHALL count as a start outside IDLE (start_err_o pulses), so back-to-back operations require start_i in IDLE.
REQ-034 sp_addr_o SHALL equal the latched target from CLEAR through WRITE, and SHALL hold its last value otherwise.
REQ-035 feed_step_o SHALL be 0 outside FEED.
REQ-036 At most one of clear_acc_o, sp_rd_en_o, feed_en_o and sp_wr_en_o SHALL be 1 in any cycle.
REQ-037 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-038 rst_ni=0 SHALL immediately force IDLE, including when asserted mid-operation, with no write-back and no done_o.
REQ-039 During reset all outputs SHALL be 0, including sp_addr_o, feed_step_o, start_err_o and all latched configuration.
REQ-040 The first cycle after rst_ni rises SHALL be IDLE and able to accept start_i.

Verification
REQ-041 Scenario: N=K=M=1, no bias, start_i at cycle 0 -> clear_acc_o at cycle 1, feed_en_o at cycle 2 with step 0, drain at cycle 3, sp_wr_en_o at cycle 4, done_o at cycle 5, busy_o high for cycles 1-4.
REQ-042 Scenario: N=K=M=4, bias, target=2 -> clear at cycle 1, sp_rd_en_o at cycle 2 with addr 2, feed_en_o for cycles 3-12 with steps 0..9, write at cycle 14 with addr 2, done at cycle 15.
REQ-043 Scenario: start_i asserted during FEED with changed dims and target -> start_err_o pulses once, and the step count and write address remain those of the original operation.
REQ-044 Scenario: rst_ni low during FEED step 3 -> all outputs 0 immediately, sp_wr_en_o never asserts, and a new start after release runs a full sequence.
REQ-045 Scenario: start_i held high continuously -> an operation starts in IDLE, start_err_o pulses every cycle from CLEAR through DONE, and the next operation starts on the IDLE cycle after DONE.
REQ-046 Scenario: N=2, K=4, M=3 -> exactly 7 feed cycles, steps 0..6.
